// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              IMEM_REQ;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic              IMEM_ACK;
  logic [15:0]       IMEM_RDATA;

  // Fetch stage side: issues requests, consumes returned words.
  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_ACK,
    input  IMEM_RDATA
  );

  // Memory side: answers requests.
  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_ACK,
    output IMEM_RDATA
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches 16-bit words over the imem bus,
// presents them on COMMAND until retired, and stops for good on HLT.
module fetch_unit #(
  parameter int unsigned           ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  fetch_unit_if.master      imem,
  input  logic              STALL,
  input  logic              PC_load,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  output logic [15:0]       COMMAND,
  output logic              CMD_VALID,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              HALTED,
  output logic [15:0]       RETIRED
);

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    HALT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              is_hlt;
  logic              accept;
  logic              retire;

  assign is_hlt = (imem.IMEM_RDATA[15:14] == 2'b11) && (imem.IMEM_RDATA[7:4] == 4'b1111);
  assign accept = (state == FETCH) && imem.IMEM_ACK;
  assign retire = (state == ISSUE) && CMD_VALID && !STALL;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:   if (imem.IMEM_ACK) state_nxt = is_hlt ? HALT : ISSUE;
      ISSUE:   if (retire)        state_nxt = FETCH;
      HALT:                       state_nxt = HALT;
      default:                    state_nxt = FETCH;
    endcase
  end

  // Bus outputs: request only while fetching and never during reset.
  always_comb begin
    imem.IMEM_REQ  = (state == FETCH) && !reset;
    imem.IMEM_ADDR = pc;
  end

  // Datapath registers: PC, instruction register, status and retire counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      COMMAND   <= '0;
      CMD_VALID <= 1'b0;
      PC_OUT    <= '0;
      HALTED    <= 1'b0;
      RETIRED   <= '0;
    end else begin
      if (accept) begin
        COMMAND <= imem.IMEM_RDATA;
        PC_OUT  <= pc;
        if (is_hlt) HALTED    <= 1'b1;
        else        CMD_VALID <= 1'b1;
      end
      if (retire) begin
        pc        <= PC_load ? BRANCH_TARGET : pc + ADDR_W'(1);
        CMD_VALID <= 1'b0;
        RETIRED   <= RETIRED + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at RESET_PC=0, one at RESET_PC=0xFFFF.
module tb_fetch_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A (RESET_PC = 0)
  logic        reset_a, stall_a, pcl_a;
  logic [15:0] bt_a, cmd_a, pco_a, ret_a;
  logic        vld_a, hlt_a;
  fetch_unit_if #(.ADDR_W(16)) bus_a ();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut_a (
    .clock(clock), .reset(reset_a), .imem(bus_a.master),
    .STALL(stall_a), .PC_load(pcl_a), .BRANCH_TARGET(bt_a),
    .COMMAND(cmd_a), .CMD_VALID(vld_a), .PC_OUT(pco_a),
    .HALTED(hlt_a), .RETIRED(ret_a)
  );

  // DUT B (RESET_PC = 0xFFFF)
  logic        reset_b, stall_b, pcl_b;
  logic [15:0] bt_b, cmd_b, pco_b, ret_b;
  logic        vld_b, hlt_b;
  fetch_unit_if #(.ADDR_W(16)) bus_b ();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_b (
    .clock(clock), .reset(reset_b), .imem(bus_b.master),
    .STALL(stall_b), .PC_load(pcl_b), .BRANCH_TARGET(bt_b),
    .COMMAND(cmd_b), .CMD_VALID(vld_b), .PC_OUT(pco_b),
    .HALTED(hlt_b), .RETIRED(ret_b)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_a = 1'b1; stall_a = 1'b0; pcl_a = 1'b0; bt_a = '0;
    bus_a.IMEM_ACK = 1'b0; bus_a.IMEM_RDATA = '0;
    reset_b = 1'b1; stall_b = 1'b0; pcl_b = 1'b0; bt_b = '0;
    bus_b.IMEM_ACK = 1'b0; bus_b.IMEM_RDATA = '0;

    // Reset state
    step(); step();
    chk("rst_req",     32'(bus_a.IMEM_REQ), 32'h0);
    chk("rst_cmd",     32'(cmd_a), 32'h0);
    chk("rst_valid",   32'(vld_a), 32'h0);
    chk("rst_pcout",   32'(pco_a), 32'h0);
    chk("rst_halted",  32'(hlt_a), 32'h0);
    chk("rst_retired", 32'(ret_a), 32'h0);

    // 1: first fetch with same-cycle ACK
    reset_a = 1'b0;
    #1;
    chk("t1_req",  32'(bus_a.IMEM_REQ), 32'h1);
    chk("t1_addr", 32'(bus_a.IMEM_ADDR), 32'h0000);
    bus_a.IMEM_ACK = 1'b1; bus_a.IMEM_RDATA = 16'h4123;
    step();
    bus_a.IMEM_ACK = 1'b0;
    chk("t1_cmd",   32'(cmd_a), 32'h4123);
    chk("t1_valid", 32'(vld_a), 32'h1);
    chk("t1_pcout", 32'(pco_a), 32'h0000);
    chk("t1_req0",  32'(bus_a.IMEM_REQ), 32'h0);

    // 2: stall holds the instruction; ACK in ISSUE is ignored
    stall_a = 1'b1;
    bus_a.IMEM_ACK = 1'b1; bus_a.IMEM_RDATA = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_cmd_hold", 32'(cmd_a), 32'h4123);
      chk("t2_vld_hold", 32'(vld_a), 32'h1);
      chk("t2_req0",     32'(bus_a.IMEM_REQ), 32'h0);
      chk("t2_ret_hold", 32'(ret_a), 32'h0);
    end
    bus_a.IMEM_ACK = 1'b0;
    stall_a = 1'b0;
    step();
    chk("t2_req",     32'(bus_a.IMEM_REQ), 32'h1);
    chk("t2_addr",    32'(bus_a.IMEM_ADDR), 32'h0001);
    chk("t2_retired", 32'(ret_a), 32'h1);
    chk("t2_valid0",  32'(vld_a), 32'h0);
    chk("t2_cmd",     32'(cmd_a), 32'h4123);

    // 3: branch target sampled only in the retire cycle
    bus_a.IMEM_ACK = 1'b1; bus_a.IMEM_RDATA = 16'h2222;
    step();
    bus_a.IMEM_ACK = 1'b0;
    chk("t3_cmd",   32'(cmd_a), 32'h2222);
    chk("t3_pcout", 32'(pco_a), 32'h0001);
    stall_a = 1'b1; pcl_a = 1'b1; bt_a = 16'h0040;
    step();
    chk("t3_stall_req", 32'(bus_a.IMEM_REQ), 32'h0);
    chk("t3_stall_ret", 32'(ret_a), 32'h1);
    stall_a = 1'b0; bt_a = 16'h0080;
    step();
    pcl_a = 1'b0; bt_a = '0;
    chk("t3_req",     32'(bus_a.IMEM_REQ), 32'h1);
    chk("t3_addr",    32'(bus_a.IMEM_ADDR), 32'h0080);
    chk("t3_retired", 32'(ret_a), 32'h2);

    // 4: RESET_PC=0xFFFF, two wait cycles, then wrap to 0
    reset_b = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_req_wait",  32'(bus_b.IMEM_REQ), 32'h1);
      chk("t4_addr_wait", 32'(bus_b.IMEM_ADDR), 32'hFFFF);
      if (i < 2) step();
    end
    bus_b.IMEM_ACK = 1'b1; bus_b.IMEM_RDATA = 16'h1111;
    step();
    bus_b.IMEM_ACK = 1'b0;
    chk("t4_valid", 32'(vld_b), 32'h1);
    chk("t4_pcout", 32'(pco_b), 32'hFFFF);
    chk("t4_cmd",   32'(cmd_b), 32'h1111);
    step();
    chk("t4_req_wrap",  32'(bus_b.IMEM_REQ), 32'h1);
    chk("t4_addr_wrap", 32'(bus_b.IMEM_ADDR), 32'h0000);
    chk("t4_retired",   32'(ret_b), 32'h1);

    // 5: HLT stops fetching until reset (DUT A is in FETCH at 0x0080)
    bus_a.IMEM_ACK = 1'b1; bus_a.IMEM_RDATA = 16'hC0F0;
    step();
    chk("t5_halted", 32'(hlt_a), 32'h1);
    chk("t5_valid",  32'(vld_a), 32'h0);
    chk("t5_cmd",    32'(cmd_a), 32'hC0F0);
    chk("t5_pcout",  32'(pco_a), 32'h0080);
    for (int i = 0; i < 20; i++) begin
      bus_a.IMEM_ACK   = 1'($urandom_range(0, 1));
      bus_a.IMEM_RDATA = 16'($urandom);
      stall_a          = 1'($urandom_range(0, 1));
      step();
      chk("t5_req0",    32'(bus_a.IMEM_REQ), 32'h0);
      chk("t5_hlt",     32'(hlt_a), 32'h1);
      chk("t5_vld0",    32'(vld_a), 32'h0);
      chk("t5_cmd_frz", 32'(cmd_a), 32'hC0F0);
      chk("t5_ret_frz", 32'(ret_a), 32'h2);
    end
    bus_a.IMEM_ACK = 1'b0; stall_a = 1'b0;
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    #1;
    chk("t5_rst_halted", 32'(hlt_a), 32'h0);
    chk("t5_rst_req",    32'(bus_a.IMEM_REQ), 32'h1);
    chk("t5_rst_addr",   32'(bus_a.IMEM_ADDR), 32'h0000);

    // 6: ACK during a reset cycle is discarded
    reset_a = 1'b1;
    bus_a.IMEM_ACK = 1'b1; bus_a.IMEM_RDATA = 16'h1234;
    #1;
    chk("t6_req_in_rst", 32'(bus_a.IMEM_REQ), 32'h0);
    step();
    reset_a = 1'b0;
    bus_a.IMEM_ACK = 1'b0;
    #1;
    chk("t6_cmd",     32'(cmd_a), 32'h0000);
    chk("t6_valid",   32'(vld_a), 32'h0);
    chk("t6_retired", 32'(ret_a), 32'h0);
    chk("t6_req",     32'(bus_a.IMEM_REQ), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
